// File: rtl/data_mem_sub_pkg.sv
// Shared size codes, FSM states and load/alignment helpers for the MEM-stage data memory.
package data_mem_sub_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Shift the addressed field down to bit 0, then sign- or zero-extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: result = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: result = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dm_ram_be.sv
// DEPTH x 32 synchronous RAM with per-byte write enables and a registered read port.
module dm_ram_be #(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [3:0]       be,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register only moves on a load so the last result stays visible.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_sub.sv
// MEM-stage data memory: byte/half/word stores with lane merge, extended sub-word loads,
// alignment faults and an optional post-reset clear sweep.
module data_mem_sub
    import data_mem_sub_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 32,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              exc,
    output logic [ADDR_W-1:0] exc_addr
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              init_we;

    logic [1:0]        lane;
    logic              misaligned, accept, fault, do_store, do_load;
    logic [3:0]        store_be;
    logic [31:0]       store_data;

    logic [3:0]        ram_be;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_idx;
    logic [31:0]       ram_wdata, ram_q;

    logic              rvalid_q, exc_q;
    logic [ADDR_W-1:0] exc_addr_q;
    logic [1:0]        ld_lane_q, ld_size_q;
    logic              ld_uns_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // ready is registered so it reads 0 during reset even when no sweep is configured.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_IDLE: ready_d = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    assign lane       = addr[1:0];
    assign misaligned = is_misaligned(size, lane);
    assign accept     = ready_q && req;
    assign fault      = accept && misaligned;
    assign do_store   = accept && !misaligned && we;
    assign do_load    = accept && !misaligned && !we;

    // Replicating the store data lets the byte enables alone pick the destination lanes.
    always_comb begin
        store_be   = 4'b1111;
        store_data = wdata;
        case (size)
            SZ_BYTE: begin
                store_be   = 4'b0001 << lane;
                store_data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                store_be   = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ram_be    = '0;
        ram_re    = 1'b0;
        ram_idx   = addr[IDX_W+1:2];
        ram_wdata = store_data;
        if (init_we) begin
            ram_be    = 4'b1111;
            ram_idx   = cnt_q;
            ram_wdata = '0;
        end else begin
            if (do_store) begin
                ram_be = store_be;
            end
            ram_re = do_load;
        end
    end

    dm_ram_be #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .clrn  (clrn),
        .be    (ram_be),
        .re    (ram_re),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rvalid_q   <= 1'b0;
            exc_q      <= 1'b0;
            exc_addr_q <= '0;
            ld_lane_q  <= '0;
            ld_size_q  <= '0;
            ld_uns_q   <= 1'b0;
        end else begin
            rvalid_q <= do_load;
            exc_q    <= fault;
            if (fault) begin
                exc_addr_q <= addr;
            end
            if (do_load) begin
                ld_lane_q <= lane;
                ld_size_q <= size;
                ld_uns_q  <= uns;
            end
        end
    end

    assign ready    = ready_q;
    assign rvalid   = rvalid_q;
    assign exc      = exc_q;
    assign exc_addr = exc_addr_q;
    assign rdata    = extend_load(ram_q, ld_lane_q, ld_size_q, ld_uns_q);

endmodule

// File: tb/tb_data_mem_sub.sv
// Self-checking bench for data_mem_sub: directed vector table, reset/sweep sequences and
// randomized accesses against a byte-array reference model.
module tb_data_mem_sub;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        clrn;
    logic        req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready, rvalid, exc;
    logic [31:0] rdata, exc_addr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_sub #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .INIT_CLEAR (1)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .req      (req),
        .we       (we),
        .size     (size),
        .uns      (uns),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .exc      (exc),
        .exc_addr (exc_addr)
    );

    typedef struct {
        bit        we;
        bit [1:0]  size;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        exp_rvalid;
        bit        exp_exc;
        bit [31:0] exp_rdata;
        bit [31:0] exp_exc_addr;
    } vec_t;

    // Reference model: memory as a flat byte array, plus the held load result and fault address.
    bit [7:0]  m_mem [DEPTH*4];
    bit [31:0] m_rdata;
    bit [31:0] m_exc_addr;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input bit r, input bit w, input bit [1:0] s, input bit u,
                                  input bit [31:0] a, input bit [31:0] d);
        req   = r;
        we    = w;
        size  = s;
        uns   = u;
        addr  = a;
        wdata = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH*4; i++) m_mem[i] = 8'h00;
        m_rdata    = 32'h0;
        m_exc_addr = 32'h0;
    endtask

    task automatic model_step(input bit w, input bit [1:0] s, input bit u, input bit [31:0] a,
                              input bit [31:0] d, output bit exp_rv, output bit exp_ex);
        int unsigned nb, base;
        bit [31:0]   val;
        exp_rv = 1'b0;
        exp_ex = 1'b0;
        nb     = (s == 2'd3) ? 0 : (1 << s);
        if (nb == 0 || (a % nb) != 0) begin
            exp_ex     = 1'b1;
            m_exc_addr = a;
            return;
        end
        base = a % (DEPTH*4);
        if (w) begin
            for (int i = 0; i < nb; i++) m_mem[base + i] = d[8*i +: 8];
        end else begin
            val = 32'h0;
            for (int i = 0; i < nb; i++) val[8*i +: 8] = m_mem[base + i];
            if (nb == 1 && !u) val = {{24{val[7]}}, val[7:0]};
            if (nb == 2 && !u) val = {{16{val[15]}}, val[15:0]};
            m_rdata = val;
            exp_rv  = 1'b1;
        end
    endtask

    // Counts edges from reset release until ready; any rvalid/exc seen meanwhile is spurious.
    task automatic wait_ready(input string name);
        int edges;
        int spurious;
        edges    = 0;
        spurious = 0;
        while (1) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (rvalid || exc) spurious++;
            if (ready || edges >= 200) break;
        end
        check_output({name, "_ready_latency"}, edges, DEPTH);
        check_output({name, "_no_spurious"}, spurious, 0);
    endtask

    vec_t vecs[16];

    initial begin
        bit exp_rv, exp_ex;
        bit r, w, u;
        bit [1:0]  s;
        bit [31:0] a, d;

        vecs[0]  = '{0, 2'b10, 0, 32'h7C, 32'h0,        1, 0, 32'h0000_0000, 32'h00};
        vecs[1]  = '{1, 2'b10, 0, 32'h08, 32'h11223344, 0, 0, 32'h0000_0000, 32'h00};
        vecs[2]  = '{0, 2'b10, 0, 32'h08, 32'h0,        1, 0, 32'h1122_3344, 32'h00};
        vecs[3]  = '{1, 2'b00, 0, 32'h0B, 32'h000000AA, 0, 0, 32'h1122_3344, 32'h00};
        vecs[4]  = '{0, 2'b10, 0, 32'h08, 32'h0,        1, 0, 32'hAA22_3344, 32'h00};
        vecs[5]  = '{0, 2'b00, 0, 32'h0B, 32'h0,        1, 0, 32'hFFFF_FFAA, 32'h00};
        vecs[6]  = '{0, 2'b00, 1, 32'h0B, 32'h0,        1, 0, 32'h0000_00AA, 32'h00};
        vecs[7]  = '{1, 2'b01, 0, 32'h0E, 32'h00008001, 0, 0, 32'h0000_00AA, 32'h00};
        vecs[8]  = '{0, 2'b01, 1, 32'h0E, 32'h0,        1, 0, 32'h0000_8001, 32'h00};
        vecs[9]  = '{0, 2'b01, 0, 32'h0E, 32'h0,        1, 0, 32'hFFFF_8001, 32'h00};
        vecs[10] = '{0, 2'b10, 0, 32'h0C, 32'h0,        1, 0, 32'h8001_0000, 32'h00};
        vecs[11] = '{1, 2'b10, 0, 32'h09, 32'h55667788, 0, 1, 32'h8001_0000, 32'h09};
        vecs[12] = '{0, 2'b10, 0, 32'h08, 32'h0,        1, 0, 32'hAA22_3344, 32'h09};
        vecs[13] = '{0, 2'b11, 0, 32'h10, 32'h0,        0, 1, 32'hAA22_3344, 32'h10};
        vecs[14] = '{1, 2'b10, 0, 32'h88, 32'hDEADBEEF, 0, 0, 32'hAA22_3344, 32'h10};
        vecs[15] = '{0, 2'b10, 0, 32'h08, 32'h0,        1, 0, 32'hDEAD_BEEF, 32'h10};

        apply_stimulus(0, 0, 2'b10, 0, 32'h0, 32'h0);
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_ready", {31'h0, ready}, 32'h0);
        check_output("reset_rvalid", {31'h0, rvalid}, 32'h0);
        check_output("reset_exc", {31'h0, exc}, 32'h0);
        check_output("reset_rdata", rdata, 32'h0);
        check_output("reset_exc_addr", exc_addr, 32'h0);
        clrn = 1'b1;
        wait_ready("init");

        // Directed table, issued back-to-back with no idle cycles between rows.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            @(posedge clk);
            @(negedge clk);
            check_output($sformatf("vec%0d_rvalid", i), {31'h0, rvalid}, {31'h0, vecs[i].exp_rvalid});
            check_output($sformatf("vec%0d_exc", i), {31'h0, exc}, {31'h0, vecs[i].exp_exc});
            check_output($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d_exc_addr", i), exc_addr, vecs[i].exp_exc_addr);
        end
        apply_stimulus(0, 0, 2'b10, 0, 32'h0, 32'h0);
        @(negedge clk);
        check_output("rvalid_one_cycle", {31'h0, rvalid}, 32'h0);

        // Reset mid-sweep with a load request held throughout.
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        apply_stimulus(1, 0, 2'b10, 0, 32'h08, 32'h0);
        repeat (10) @(negedge clk);
        check_output("midinit_not_ready", {31'h0, ready}, 32'h0);
        clrn = 1'b0;
        @(negedge clk);
        check_output("midinit_rdata_cleared", rdata, 32'h0);
        check_output("midinit_exc_addr_cleared", exc_addr, 32'h0);
        clrn = 1'b1;
        wait_ready("restart");
        apply_stimulus(0, 0, 2'b10, 0, 32'h0, 32'h0);
        @(negedge clk);

        model_reset();
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1);
            u = $urandom_range(0, 1);
            s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 4) != 0 && s != 2'b11) a = a & ~((32'h1 << s) - 32'h1);
            if ($urandom_range(0, 1) == 1) a = a & 32'h0000_00FF;
            d = $urandom;
            apply_stimulus(r, w, s, u, a, d);
            @(posedge clk);
            @(negedge clk);
            exp_rv = 1'b0;
            exp_ex = 1'b0;
            if (r) model_step(w, s, u, a, d, exp_rv, exp_ex);
            check_output("rand_rvalid", {31'h0, rvalid}, {31'h0, exp_rv});
            check_output("rand_exc", {31'h0, exc}, {31'h0, exp_ex});
            check_output("rand_rdata", rdata, m_rdata);
            check_output("rand_exc_addr", exc_addr, m_exc_addr);
            check_output("rand_ready", {31'h0, ready}, 32'h1);
        end
        apply_stimulus(0, 0, 2'b10, 0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
